// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the 256x8 data memory: load/store/push/pop over valid/ready.
// Define MEM_ACCESS_PROTECT_EN to fault low-region LOAD/STORE and stack overflow/underflow.
module mem_access_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           DATA_BASE  = 128,
  parameter logic [ADDR_WIDTH-1:0] SP_RESET   = 8'hFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [2:0]            i_req_op,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_wen,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [ADDR_WIDTH-1:0] o_sp
);

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpLoad  = 3'd1;
  localparam logic [2:0] OpStore = 3'd2;
  localparam logic [2:0] OpPush  = 3'd3;
  localparam logic [2:0] OpPop   = 3'd4;

`ifdef MEM_ACCESS_PROTECT_EN
  localparam bit ProtectEn = 1'b1;
`else
  localparam bit ProtectEn = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] BaseAddr  = ADDR_WIDTH'(DATA_BASE);
  localparam logic [ADDR_WIDTH-1:0] StackFull = ADDR_WIDTH'(DATA_BASE - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [2:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_sp;
  logic [ADDR_WIDTH-1:0] w_sp_d;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [DATA_WIDTH-1:0] w_rdata_d;
  logic                  r_rsp_err;
  logic                  w_fault;
  logic                  w_accept;

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_sp        = r_sp;
  assign w_accept    = o_req_ready & i_req_valid;

  always_comb begin
    w_fault = (r_op > OpPop);
    if (ProtectEn) begin
      case (r_op)
        OpLoad, OpStore: w_fault = (r_addr < BaseAddr);
        OpPush:          w_fault = (r_sp == StackFull);
        OpPop:           w_fault = (r_sp == '1);
        default:         ;
      endcase
    end
  end

  always_comb begin
    w_state_d   = r_state;
    o_req_ready = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wen   = 1'b0;
    w_rdata_d   = '0;
    w_sp_d      = r_sp;
    case (r_state)
      StIdle: begin
        o_req_ready = ~i_rst;
        if (w_accept) w_state_d = StAccess;
      end
      StAccess: begin
        w_state_d = StDone;
        if (!w_fault) begin
          case (r_op)
            OpLoad: begin
              o_mem_addr = r_addr;
              w_rdata_d  = i_mem_rdata;
            end
            OpStore: begin
              o_mem_addr  = r_addr;
              o_mem_wdata = r_wdata;
              o_mem_wen   = ~i_rst;
            end
            OpPush: begin
              o_mem_addr  = r_sp;
              o_mem_wdata = r_wdata;
              o_mem_wen   = ~i_rst;
              w_sp_d      = r_sp - ADDR_WIDTH'(1);
            end
            OpPop: begin
              o_mem_addr = r_sp + ADDR_WIDTH'(1);
              w_rdata_d  = i_mem_rdata;
              w_sp_d     = r_sp + ADDR_WIDTH'(1);
            end
            default: ;
          endcase
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_op        <= OpNop;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sp        <= SP_RESET;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_rsp_valid <= (r_state == StAccess);
      r_sp        <= w_sp_d;
      if (w_accept) begin
        r_op    <= i_req_op;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
      end
      // Response fields are captured only here so they hold until the next response.
      if (r_state == StAccess) begin
        r_rsp_rdata <= w_rdata_d;
        r_rsp_err   <= w_fault;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table, corner sequences and random
// traffic against a transaction-level stack/memory model.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_PROTECT_EN
  localparam bit Prot = 1'b1;
`else
  localparam bit Prot = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_req_valid = 1'b0;
  logic       o_req_ready;
  logic [2:0] i_req_op = '0;
  logic [7:0] i_req_addr = '0;
  logic [7:0] i_req_wdata = '0;
  logic       o_rsp_valid;
  logic [7:0] o_rsp_rdata;
  logic       o_rsp_err;
  logic [7:0] o_mem_addr;
  logic [7:0] o_mem_wdata;
  logic       o_mem_wen;
  logic [7:0] i_mem_rdata;
  logic [7:0] o_sp;

  mem_access_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (i_req_op),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wen   (o_mem_wen),
    .i_mem_rdata (i_mem_rdata),
    .o_sp        (o_sp)
  );

  always #5 i_clk = ~i_clk;

  // Memory behind the port: combinational read, write on the rising edge.
  logic [7:0] mem [256];
  assign i_mem_rdata = mem[o_mem_addr];
  always @(posedge i_clk) if (o_mem_wen) mem[o_mem_addr] <= o_mem_wdata;

  // Reference model state.
  logic [7:0] m_mem [256];
  logic [7:0] m_sp;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] e_rdata;
    logic       e_err;
    logic [7:0] e_sp;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Transaction-level model: a byte array plus a post-decrement stack pointer.
  task automatic model_step(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                            output logic [7:0] rdata, output logic err);
    rdata = 8'h00;
    err   = 1'b0;
    case (op)
      3'd0: ;
      3'd1: if (Prot && addr < 8'd128) err = 1'b1; else rdata = m_mem[addr];
      3'd2: if (Prot && addr < 8'd128) err = 1'b1; else m_mem[addr] = wdata;
      3'd3: if (Prot && m_sp == 8'd127) err = 1'b1;
            else begin m_mem[m_sp] = wdata; m_sp = m_sp - 8'd1; end
      3'd4: if (Prot && m_sp == 8'hFF) err = 1'b1;
            else begin m_sp = m_sp + 8'd1; rdata = m_mem[m_sp]; end
      default: err = 1'b1;
    endcase
  endtask

  task automatic run_req(input string tag, input logic [2:0] op, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] e_rdata, input logic e_err,
                         input logic [7:0] e_sp);
    for (int k = 0; k < 8 && !o_req_ready; k++) tick();
    chk({tag, ".ready_idle"}, o_req_ready, 1);
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    tick();
    // ACCESS: optionally keep valid up with junk to prove it is ignored.
    chk({tag, ".ready_access"}, o_req_ready, 0);
    chk({tag, ".rsp_early"}, o_rsp_valid, 0);
    if ($urandom_range(0, 1) == 1) begin
      i_req_op    = 3'($urandom);
      i_req_addr  = 8'($urandom);
      i_req_wdata = 8'($urandom);
    end else begin
      i_req_valid = 1'b0;
    end
    tick();
    i_req_valid = 1'b0;
    chk({tag, ".rsp_valid"}, o_rsp_valid, 1);
    chk({tag, ".rdata"}, o_rsp_rdata, e_rdata);
    chk({tag, ".err"}, o_rsp_err, e_err);
    chk({tag, ".sp"}, o_sp, e_sp);
    chk({tag, ".ready_done"}, o_req_ready, 0);
    tick();
    chk({tag, ".rsp_drop"}, o_rsp_valid, 0);
    chk({tag, ".ready_back"}, o_req_ready, 1);
    chk({tag, ".rdata_hold"}, o_rsp_rdata, e_rdata);
    chk({tag, ".err_hold"}, o_rsp_err, e_err);
  endtask

  task automatic model_req(input string tag, input logic [2:0] op, input logic [7:0] addr,
                           input logic [7:0] wdata);
    logic [7:0] r;
    logic       e;
    model_step(op, addr, wdata, r, e);
    run_req(tag, op, addr, wdata, r, e, m_sp);
  endtask

  initial begin
    logic [7:0] dr;
    logic       de;
    int         diffs;

    vecs[0]  = '{3'd1, 8'd200, 8'h00, 8'd128, 1'b0, 8'hFF};
    vecs[1]  = '{3'd2, 8'd200, 8'd150, 8'h00, 1'b0, 8'hFF};
    vecs[2]  = '{3'd1, 8'd200, 8'h00, 8'd150, 1'b0, 8'hFF};
    vecs[3]  = '{3'd3, 8'h00, 8'h11, 8'h00, 1'b0, 8'hFE};
    vecs[4]  = '{3'd3, 8'h00, 8'h22, 8'h00, 1'b0, 8'hFD};
    vecs[5]  = '{3'd4, 8'h00, 8'h00, 8'h22, 1'b0, 8'hFE};
    vecs[6]  = '{3'd4, 8'h00, 8'h00, 8'h11, 1'b0, 8'hFF};
    vecs[7]  = '{3'd0, 8'd7, 8'd9, 8'h00, 1'b0, 8'hFF};
    vecs[8]  = '{3'd6, 8'd200, 8'h55, 8'h00, 1'b1, 8'hFF};
    vecs[9]  = '{3'd7, 8'd200, 8'h55, 8'h00, 1'b1, 8'hFF};
`ifdef MEM_ACCESS_PROTECT_EN
    vecs[10] = '{3'd2, 8'd5, 8'hAB, 8'h00, 1'b1, 8'hFF};
    vecs[11] = '{3'd1, 8'd5, 8'h00, 8'h00, 1'b1, 8'hFF};
    vecs[12] = '{3'd4, 8'h00, 8'h00, 8'h00, 1'b1, 8'hFF};
    vecs[13] = '{3'd3, 8'h00, 8'h44, 8'h00, 1'b0, 8'hFE};
    vecs[14] = '{3'd4, 8'h00, 8'h00, 8'h44, 1'b0, 8'hFF};
`else
    vecs[10] = '{3'd2, 8'd5, 8'hAB, 8'h00, 1'b0, 8'hFF};
    vecs[11] = '{3'd1, 8'd5, 8'h00, 8'hAB, 1'b0, 8'hFF};
    vecs[12] = '{3'd4, 8'h00, 8'h00, 8'hA5, 1'b0, 8'h00};
    vecs[13] = '{3'd3, 8'h00, 8'h44, 8'h00, 1'b0, 8'hFF};
    vecs[14] = '{3'd4, 8'h00, 8'h00, 8'h44, 1'b0, 8'h00};
`endif

    for (int i = 0; i < 256; i++) begin
      mem[i]   <= 8'(i) ^ 8'hA5;
      m_mem[i] = 8'(i) ^ 8'hA5;
    end
    mem[200]   <= 8'd128;
    m_mem[200] = 8'd128;
    m_sp       = 8'hFF;

    repeat (3) tick();
    chk("rst.ready", o_req_ready, 0);
    chk("rst.sp", o_sp, 8'hFF);
    chk("rst.rsp_valid", o_rsp_valid, 0);
    chk("rst.rsp_err", o_rsp_err, 0);
    chk("rst.rsp_rdata", o_rsp_rdata, 0);
    chk("rst.mem_wen", o_mem_wen, 0);
    chk("rst.mem_addr", o_mem_addr, 0);
    chk("rst.mem_wdata", o_mem_wdata, 0);
    i_rst = 1'b0;
    #1;
    chk("rst.ready_after", o_req_ready, 1);

    for (int i = 0; i < 15; i++) begin
      model_step(vecs[i].op, vecs[i].addr, vecs[i].wdata, dr, de);
      run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
              vecs[i].e_rdata, vecs[i].e_err, vecs[i].e_sp);
      if (i == 1) chk("vec1.mem200", mem[200], 8'd150);
      if (i == 6) chk("vec6.mem255", mem[255], 8'h11);
      if (i == 10) chk("vec10.mem5", mem[5], Prot ? 8'hA0 : 8'hAB);
    end

    // Reset during the ACCESS cycle of a STORE: no write, no response.
    for (int k = 0; k < 8 && !o_req_ready; k++) tick();
    i_req_valid = 1'b1;
    i_req_op    = 3'd2;
    i_req_addr  = 8'd200;
    i_req_wdata = 8'h77;
    tick();
    i_req_valid = 1'b0;
    i_rst       = 1'b1;
    #1;
    chk("midrst.mem_wen", o_mem_wen, 0);
    tick();
    chk("midrst.rsp_valid", o_rsp_valid, 0);
    chk("midrst.ready_in_rst", o_req_ready, 0);
    chk("midrst.sp", o_sp, 8'hFF);
    chk("midrst.mem200", mem[200], m_mem[200]);
    i_rst = 1'b0;
    m_sp  = 8'hFF;
    #1;
    chk("midrst.ready_after", o_req_ready, 1);
    tick();
    chk("midrst.no_rsp", o_rsp_valid, 0);

    if (Prot) begin
      for (int i = 0; i < 129; i++) model_req($sformatf("ovf%0d", i), 3'd3, 8'h00, 8'(i));
      chk("ovf.sp_final", o_sp, 8'd127);
      chk("ovf.err_final", o_rsp_err, 1);
    end

    for (int n = 0; n < 300; n++) begin
      int         r;
      logic [2:0] op;
      logic [7:0] addr;
      r    = $urandom_range(0, 15);
      op   = (r < 14) ? 3'(r % 5) : 3'(5 + r % 3);
      addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(128, 255)) : 8'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      model_req($sformatf("rnd%0d", n), op, addr, 8'($urandom));
    end

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) diffs++;
    chk("final.mem_words_differing", diffs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side controller for the 256x8 data memory: it accepts load/store/push/pop requests from the MEM pipeline stage over a valid/ready handshake and drives the memory's write-capable port (address, write data, write enable). It returns a registered response and maintains the hardware stack pointer. It sits between the MEM stage and port 2 of the shared memory, whose reads are combinational and whose writes take effect on the rising clock edge.

## Interface
- `ADDR_WIDTH`, 8: memory address width.
- `DATA_WIDTH`, 8: memory word width.
- `DATA_BASE`, 128: lowest data/stack address; the region below it is protected.
- `SP_RESET`, 8'hFF: stack pointer value after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the controller accepts a request this cycle.
- `req_op` in 3: request opcode.
  - 0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP.
  - 5–7 are reserved.
- `req_addr` in ADDR_WIDTH: address for LOAD/STORE; ignored for the other opcodes.
- `req_wdata` in DATA_WIDTH: data for STORE/PUSH.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DATA_WIDTH: load/pop data; 0 for all other responses.
- `rsp_err` out 1: the request faulted; qualified by `rsp_valid`.
- `mem_addr` out ADDR_WIDTH: memory port address.
- `mem_wdata` out DATA_WIDTH: memory port write data.
- `mem_wen` out 1: memory port write enable.
- `mem_rdata` in DATA_WIDTH: memory port read data (combinational from `mem_addr`).
- `sp` out ADDR_WIDTH: current stack pointer.

## Operation
- FSM states:
  - IDLE → ACCESS when `req_valid & req_ready`.
  - ACCESS → DONE unconditionally.
  - DONE → IDLE unconditionally.
- `req_ready` = 1 only in IDLE. On acceptance, `req_op`, `req_addr` and `req_wdata` are latched.
- ACCESS drives the memory port from the latched values. Outside ACCESS, `mem_addr`, `mem_wdata` and `mem_wen` are 0.
- LOAD: `mem_addr` = addr. `mem_rdata` is captured into `rsp_rdata` at the end of ACCESS.
- STORE: `mem_addr` = addr, `mem_wdata` = data, `mem_wen` = 1.
- PUSH (post-decrement):
  - Write data to address `sp`.
  - `sp` <= `sp` − 1 at the end of ACCESS.
- POP (pre-increment):
  - Read address `sp` + 1 (mod 256).
  - `sp` <= `sp` + 1 at the end of ACCESS.
- NOP: no memory access; response is `rsp_rdata` = 0, `rsp_err` = 0.
- Reserved opcode: no memory access; `rsp_err` = 1.
- On any faulting request:
  - `mem_wen` stays 0.
  - `sp` is unchanged.
  - `rsp_rdata` = 0 and `rsp_err` = 1.
  - The FSM still passes through ACCESS and DONE.
- `sp` arithmetic is modulo 2^ADDR_WIDTH.

## Timing
- Reset values:
  - State IDLE.
  - `sp` = SP_RESET.
  - `rsp_valid`, `rsp_err` and `rsp_rdata` = 0.
  - `mem_*` = 0.
  - `req_ready` = 0 while `rst` is high, 1 in the first cycle after.
- Acceptance in cycle N (IDLE):
  - Memory access in cycle N+1 (ACCESS). A STORE/PUSH write lands at the edge ending N+1.
  - `rsp_valid` is high for exactly cycle N+2 (DONE).
  - The next request can be accepted in cycle N+3. Throughput is one request per 3 cycles.
- `rsp_rdata` and `rsp_err` are registered. They hold their value after DONE until the next response.
- `mem_wen` is gated by `~rst`: reset asserted during ACCESS causes no write and no `sp` update. The FSM returns to IDLE and no response is issued.
- `req_valid` is ignored outside IDLE; the requester holds the request until it sees `req_ready`.

## Configuration
- Macro `MEM_ACCESS_PROTECT_EN`.
- Defined: the following requests fault.
  - LOAD/STORE with addr < DATA_BASE.
  - PUSH when `sp` == DATA_BASE − 1 (overflow).
  - POP when `sp` == 8'hFF (underflow).
- Undefined: no address or stack checks; `sp` wraps freely. Only reserved opcodes set `rsp_err`.

## Test plan
- Reset, memory preloaded with 128 at address 200, then LOAD addr 200 → `rsp_valid` exactly 2 cycles after acceptance, `rsp_rdata` = 128, `rsp_err` = 0, `req_ready` low for 2 cycles.
- STORE addr 200 data 150, then LOAD 200 → memory word 200 = 150 after ACCESS; load returns 150.
- PUSH 0x11, PUSH 0x22, POP, POP → `sp` goes 255→254→253→254→255; pops return 0x22 then 0x11; `mem[255]` = 0x11.
- With `MEM_ACCESS_PROTECT_EN`:
  - STORE addr 5 → `rsp_err` = 1, `mem[5]` unchanged.
  - POP at reset → `rsp_err` = 1, `sp` stays 255.
  - 128 PUSHes succeed, the 129th errs with `sp` = 127.
- Without `MEM_ACCESS_PROTECT_EN`: POP at reset → reads `mem[0]`, `sp` = 0, `rsp_err` = 0. Opcode 6 → `rsp_err` = 1.
- Assert `rst` during the ACCESS cycle of a STORE → memory unchanged, no `rsp_valid`, `sp` = 255, `req_ready` = 1 the cycle after reset releases.
